// File: rtl/plab4_net_router_input_unit_pkg.sv
// ============================================================================
// plab4_net_router_input_unit_pkg : port indices and destination-field helpers
// Revision: 1.0
// ============================================================================
`default_nettype none

package plab4_net_router_input_unit_pkg;

  localparam int PORT_PREV = 0;
  localparam int PORT_TERM = 1;
  localparam int PORT_NEXT = 2;
  localparam int NUM_PORTS = 3;

  // Destination router id occupies the most significant bits of a message
  function automatic int dest_lsb(input int msg_nbits, input int dest_nbits);
    return msg_nbits - dest_nbits;
  endfunction

  function automatic int dest_msb(input int msg_nbits);
    return msg_nbits - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/plab4_net_router_input_queue.sv
// ============================================================================
// plab4_net_router_input_queue : val/rdy FIFO holding message plus domain bit
// Revision: 1.0
// ============================================================================
`default_nettype none

module plab4_net_router_input_queue
  import plab4_net_router_input_unit_pkg::*;
#(
  parameter int p_msg_nbits = 44,
  parameter int p_depth     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enq_val_i,
  output logic                   enq_rdy_o,
  input  logic [p_msg_nbits-1:0] enq_msg_i,
  input  logic                   enq_sd_i,
  input  logic                   deq_i,
  output logic [p_msg_nbits-1:0] head_msg_o,
  output logic                   head_sd_o,
  output logic                   empty_o
);

  localparam int              c_aw    = $clog2(p_depth);
  localparam logic [c_aw:0]   c_depth = (c_aw + 1)'(p_depth);

  logic [p_msg_nbits-1:0] msg_mem [p_depth];
  logic [p_depth-1:0]     sd_mem;

  logic [c_aw-1:0] wptr_q, wptr_d;
  logic [c_aw-1:0] rptr_q, rptr_d;
  logic [c_aw:0]   count_q, count_d;
  logic            w_enq;
  logic            w_deq;

  // Ready looks only at occupancy, so a full queue refuses even on a dequeue cycle
  assign enq_rdy_o = rst_n && (count_q < c_depth);
  assign empty_o   = (count_q == '0);
  assign w_enq     = enq_val_i && enq_rdy_o;
  assign w_deq     = deq_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (w_enq) wptr_d = wptr_q + c_aw'(1);
    if (w_deq) rptr_d = rptr_q + c_aw'(1);
    case ({w_enq, w_deq})
      2'b10:   count_d = count_q + (c_aw + 1)'(1);
      2'b01:   count_d = count_q - (c_aw + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      msg_mem[wptr_q] <= enq_msg_i;
      sd_mem[wptr_q]  <= enq_sd_i;
    end
  end

  assign head_msg_o = msg_mem[rptr_q];
  assign head_sd_o  = sd_mem[rptr_q];

endmodule

`default_nettype wire

// File: rtl/plab4_net_router_input_unit.sv
// ============================================================================
// plab4_net_router_input_unit : ring-router input buffer with shortest-path request
// Revision: 1.0
// ============================================================================
`default_nettype none

module plab4_net_router_input_unit
  import plab4_net_router_input_unit_pkg::*;
#(
  parameter int p_msg_nbits   = 44,
  parameter int p_dest_nbits  = 2,
  parameter int p_router_id   = 0,
  parameter int p_num_routers = 4,
  parameter int p_queue_depth = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [p_msg_nbits-1:0] in_msg,
  input  logic                   in_sd,
  input  logic                   cur_sd,
  output logic [NUM_PORTS-1:0]   reqs,
  input  logic [NUM_PORTS-1:0]   grants,
  output logic [p_msg_nbits-1:0] out_msg,
  output logic                   out_sd
);

  localparam int                    c_dest_lsb = dest_lsb(p_msg_nbits, p_dest_nbits);
  localparam int                    c_fw       = p_dest_nbits + 1;
  localparam logic [p_dest_nbits:0] c_num      = c_fw'(p_num_routers);
  localparam logic [p_dest_nbits:0] c_id       = c_fw'(p_router_id);
  localparam logic [p_dest_nbits:0] c_half     = c_fw'(p_num_routers / 2);

  logic                    w_empty;
  logic                    w_deq;
  logic [p_dest_nbits-1:0] w_dest;
  logic [p_dest_nbits:0]   w_sum;
  logic [p_dest_nbits:0]   w_fwd;
  logic [NUM_PORTS-1:0]    w_route;

  plab4_net_router_input_queue #(
    .p_msg_nbits (p_msg_nbits),
    .p_depth     (p_queue_depth)
  ) u_queue (
    .clk        (clk),
    .rst_n      (reset),
    .enq_val_i  (in_val),
    .enq_rdy_o  (in_rdy),
    .enq_msg_i  (in_msg),
    .enq_sd_i   (in_sd),
    .deq_i      (w_deq),
    .head_msg_o (out_msg),
    .head_sd_o  (out_sd),
    .empty_o    (w_empty)
  );

  // Adding N before subtracting the id keeps the extra-bit difference non-negative
  assign w_dest = out_msg[c_dest_lsb +: p_dest_nbits];
  assign w_sum  = {1'b0, w_dest} + c_num - c_id;
  assign w_fwd  = (w_sum >= c_num) ? (w_sum - c_num) : w_sum;

  always_comb begin
    w_route = '0;
    if ({1'b0, w_dest} == c_id)
      w_route[PORT_TERM] = 1'b1;
    else if (w_fwd <= c_half)
      w_route[PORT_NEXT] = 1'b1;
    else
      w_route[PORT_PREV] = 1'b1;
  end

  // Requests never look at grants, keeping the request/grant loop acyclic
  assign reqs  = (!w_empty && (out_sd == cur_sd)) ? w_route : '0;
  assign w_deq = |(reqs & grants);

endmodule

`default_nettype wire

// File: tb/tb_plab4_net_router_input_unit.sv
// ============================================================================
// tb_plab4_net_router_input_unit : scoreboard bench with behavioural routing model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_plab4_net_router_input_unit;

  localparam int MW    = 44;
  localparam int DW    = 2;
  localparam int ID    = 1;
  localparam int NR    = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [MW-1:0] msg;
    logic          sd;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_val;
  logic          in_rdy;
  logic [MW-1:0] in_msg;
  logic          in_sd;
  logic          cur_sd;
  logic [2:0]    reqs;
  logic [2:0]    grants;
  logic [MW-1:0] out_msg;
  logic          out_sd;

  int   n_checks = 0;
  int   n_fails  = 0;
  ent_t mq[$];
  ent_t sb[$];

  plab4_net_router_input_unit #(
    .p_msg_nbits   (MW),
    .p_dest_nbits  (DW),
    .p_router_id   (ID),
    .p_num_routers (NR),
    .p_queue_depth (DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_msg  (in_msg),
    .in_sd   (in_sd),
    .cur_sd  (cur_sd),
    .reqs    (reqs),
    .grants  (grants),
    .out_msg (out_msg),
    .out_sd  (out_sd)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Shortest way round the ring, ties going forward
  function automatic logic [2:0] route_of(input int d);
    int fwd;
    if (d == ID) return 3'b010;
    fwd = ((d - ID) % NR + NR) % NR;
    if (fwd <= NR / 2) return 3'b100;
    return 3'b001;
  endfunction

  function automatic logic [2:0] model_reqs(input logic c);
    if (mq.size() == 0) return 3'b000;
    if (mq[0].sd != c) return 3'b000;
    return route_of(int'(mq[0].msg[MW-1 -: DW]));
  endfunction

  function automatic logic [MW-1:0] mk(input int d);
    logic [MW-1:0] r;
    logic [DW-1:0] dd;
    r  = MW'({$urandom, $urandom});
    dd = DW'(d);
    r[MW-1 -: DW] = dd;
    return r;
  endfunction

  task automatic step(input logic v, input logic [MW-1:0] m, input logic s,
                      input logic c, input logic [2:0] g);
    logic [2:0] er;
    logic       erdy;
    ent_t       e;
    @(posedge clk);
    #1;
    in_val = v; in_msg = m; in_sd = s; cur_sd = c; grants = g;
    @(negedge clk);
    erdy = (mq.size() < DEPTH);
    er   = model_reqs(c);
    cmp("in_rdy", {63'd0, in_rdy}, {63'd0, erdy});
    cmp("reqs", {61'd0, reqs}, {61'd0, er});
    if ((er & g) != 3'b000) mq.delete(0);
    if (v && erdy) begin
      e.msg = m; e.sd = s;
      mq.push_back(e);
      sb.push_back(e);
    end
  endtask

  // Monitor: every completed transfer must present the next expected message
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && (reqs & grants) != 3'b000) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL deq_when_empty: got reqs&grants %0b expected none", reqs & grants);
        end else begin
          e = sb.pop_front();
          cmp("out_msg", {20'd0, out_msg}, {20'd0, e.msg});
          cmp("out_sd", {63'd0, out_sd}, {63'd0, e.sd});
        end
      end
    end
  end

  initial begin
    int   dsw[4];
    logic c;
    reset = 1'b1; in_val = 1'b0; in_msg = '0; in_sd = 1'b0; cur_sd = 1'b0; grants = 3'b000;
    dsw[0] = 2; dsw[1] = 3; dsw[2] = 0; dsw[3] = 1;

    #1 reset = 1'b0;
    #1;
    cmp("reset_in_rdy", {63'd0, in_rdy}, 64'd0);
    cmp("reset_reqs", {61'd0, reqs}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    cmp("first_cycle_in_rdy", {63'd0, in_rdy}, 64'd1);
    cmp("first_cycle_reqs", {61'd0, reqs}, 64'd0);

    // Route sweep, each message granted the cycle after it is accepted
    for (int i = 0; i < 4; i++) begin
      step(1'b1, mk(dsw[i]), 1'b0, 1'b0, 3'b000);
      step(1'b0, '0, 1'b0, 1'b0, model_reqs(1'b0));
    end
    step(1'b0, '0, 1'b0, 1'b0, 3'b111);

    // Fill to capacity, then offer one more alongside a grant
    for (int i = 0; i < DEPTH; i++) step(1'b1, mk(i), 1'b0, 1'b0, 3'b000);
    step(1'b1, mk(2), 1'b0, 1'b0, model_reqs(1'b0));
    step(1'b0, '0, 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b0, 1'b0, 3'b111);

    // Domain stall, then release in the same cycle cur_sd flips
    step(1'b1, mk(3), 1'b1, 1'b0, 3'b000);
    step(1'b1, mk(0), 1'b1, 1'b0, 3'b000);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 1'b0, 3'b111);
    step(1'b0, '0, 1'b0, 1'b1, 3'b000);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1, 3'b111);

    // Steady-state enqueue plus dequeue with pointer wrap
    step(1'b1, mk(2), 1'b0, 1'b0, 3'b000);
    step(1'b1, mk(0), 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 20; i++) step(1'b1, mk(int'($urandom_range(0, 3))), 1'b0, 1'b0, 3'b111);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0, 3'b111);

    // Random traffic, domains and grants
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), mk(int'($urandom_range(0, 3))),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           3'($urandom_range(0, 7)));
    for (int i = 0; i < 8; i++) begin
      c = (mq.size() != 0) ? mq[0].sd : 1'b0;
      step(1'b0, '0, 1'b0, c, 3'b111);
    end
    @(posedge clk);
    cmp("scoreboard_drained", 64'(sb.size()), 64'd0);

    // Reset in the middle of a stream drops everything buffered
    for (int i = 0; i < 3; i++) step(1'b1, mk(i), 1'b0, 1'b0, 3'b000);
    @(posedge clk);
    #3 reset = 1'b0; in_val = 1'b1; grants = 3'b111;
    #1;
    cmp("midreset_in_rdy", {63'd0, in_rdy}, 64'd0);
    cmp("midreset_reqs", {61'd0, reqs}, 64'd0);
    mq.delete();
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; in_val = 1'b0;
    @(negedge clk);
    cmp("post_reset_in_rdy", {63'd0, in_rdy}, 64'd1);
    cmp("post_reset_reqs", {61'd0, reqs}, 64'd0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 3'b111);
    step(1'b1, mk(1), 1'b0, 1'b0, 3'b000);
    step(1'b0, '0, 1'b0, 1'b0, 3'b010);
    step(1'b0, '0, 1'b0, 1'b0, 3'b111);

    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/plab4_net_router_input_unit.md
# plab4_net_router_input_unit

Input-side unit of a three-port ring router, the request/grant counterpart of the per-output round-robin controllers. It buffers arriving messages in a small FIFO and computes the shortest-path output port for the head message. It issues a one-hot request to the three output controllers, tagged with the message's security domain, and dequeues the head on the cycle a matching grant returns. One instance sits on each router input: prev-ring, terminal, next-ring.

## Interface

- p_msg_nbits, 44, message width; destination field is the top p_dest_nbits bits
- p_dest_nbits, 2, destination router-id field width
- p_router_id, 0, this router's id, 0..p_num_routers-1
- p_num_routers, 4, routers on the ring, ≥2, ≤ 2^p_dest_nbits
- p_queue_depth, 4, FIFO entries, power of two, ≥2
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- in_val  input  1  upstream message valid
- in_rdy  output  1  unit can accept a message
- in_msg  input  p_msg_nbits  upstream message
- in_sd  input  1  security domain of in_msg, stored with it
- cur_sd  input  1  domain currently allowed to use the outputs
- reqs  output  3  one-hot request: bit 0 prev, bit 1 terminal, bit 2 next
- grants  input  3  grant bit for this input from each output controller
- out_msg  output  p_msg_nbits  head message, driven to the crossbar
- out_sd  output  1  domain of the head message

## Operation

- FIFO: write pointer, read pointer and count, each log2(p_queue_depth) bits; count has one extra bit. Pointers wrap modulo depth.
- Enqueue: in_val && in_rdy. Dequeue: (reqs & grants) != 0.
- in_rdy = (count < p_queue_depth) while reset is deasserted. It has no combinational dependence on dequeue, so a full FIFO refuses input even on a dequeue cycle.
- Enqueue and dequeue may occur in the same cycle when not full. Count is unchanged; both pointers advance.
- Empty FIFO: no bypass. A message enqueued in cycle t reaches the head in cycle t+1.
- Routing of the head message, d = destination field:
  - d == p_router_id: route to terminal (bit 1).
  - Otherwise compute fwd = (d − p_router_id) mod p_num_routers, with width p_dest_nbits+1 so negative differences cannot underflow.
  - fwd ≤ p_num_routers/2 (integer division): route to next (bit 2). Ties go to next.
  - Otherwise route to prev (bit 0).
- reqs = route one-hot only when the FIFO is not empty and head sd == cur_sd; otherwise reqs = 3'b000.
- Grant bits whose corresponding reqs bit is 0 are ignored and cause no dequeue.
- A head message whose domain differs from cur_sd stalls, holding its position, until cur_sd matches. There is no reordering.
- out_msg and out_sd always show the head entry. They are don't-care when the FIFO is empty, but are driven from storage with no X-generation logic.

## Timing

- Reset (asynchronous assert, synchronous-edge deassert): pointers and count clear to 0, in_rdy = 0, reqs = 0. Storage contents are not reset.
- First cycle after reset deasserts: in_rdy = 1, reqs = 0.
- Latency: minimum one cycle from accept to request. With an immediate grant, a message accepted in cycle t departs in cycle t+1.
- A grant is a completed transfer. Output controllers grant only when their downstream is ready, so no extra handshake exists. Head, reqs and route update in the cycle after a dequeue.
- reqs is combinational from FIFO state and cur_sd only. It never depends on grants, so the input/output request/grant loop stays acyclic.
- A cur_sd change takes effect on reqs in the same cycle.
- Reset asserted mid-transfer drops all buffered messages. Upstream must resend.

## Structure

- Shared package holds:
  - port index constants: PORT_PREV=0, PORT_TERM=1, PORT_NEXT=2
  - destination-field offset/width helpers used by every router unit
- Sub-module plab4_net_router_input_queue: parameterized FIFO with val/rdy enqueue and a deq strobe, holding msg+sd.
- The top level holds the route computation and the request gating.

## Test plan

- Reset, then p_router_id=0 and N=4: enqueue a d=0 message in cycle 1. Cycle 2: reqs=3'b010. Grant 3'b010 → dequeue; cycle 3: reqs=0, count=0.
- Route sweep at p_router_id=1, N=4: d=2 → 3'b100; d=3 (fwd=2, tie) → 3'b100; d=0 (fwd=3) → 3'b001; d=1 → 3'b010.
- Fill 4 messages with no grants → in_rdy=0 after the 4th. Assert in_val with a grant in the same cycle → no enqueue; next cycle in_rdy=1 and count=3.
- Head sd=1 with cur_sd=0 → reqs=0 for 10 cycles. Flip cur_sd=1 → reqs asserted the same cycle, and FIFO order is preserved.
- Simultaneous enqueue and dequeue over 20 cycles with pointer wrap → out_msg sequence equals the input sequence and count stays constant.
- Assert reset low mid-stream with 3 messages queued → in_rdy=0 and reqs=0 immediately. After release, count=0 and no stale requests.
